// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default datapath width and the quotient reported on divide-by-zero.
package div_pkg;
  localparam int unsigned DIV_WIDTH = 16;
  localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_divider16_cla17_sub_step.sv
// 17-bit combinational subtract a - b computed as a + ~b + 1, four 4-bit
// carry-lookahead groups rippled together plus one extra top bit.
module cla17_sub_step (
  input  logic [16:0] a,
  input  logic [16:0] b,
  output logic [16:0] diff,
  output logic        borrow
);
  logic [16:0] p;
  logic [16:0] g;
  logic [17:0] c;

  assign p    = a ^ ~b;
  assign g    = a & ~b;
  assign c[0] = 1'b1;

  for (genvar k = 0; k < 4; k++) begin : grp
    localparam int unsigned B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign c[17]  = g[16] | (p[16] & c[16]);
  assign diff   = p ^ c[16:0];
  assign borrow = ~c[17];
endmodule

// File: rtl/seq_divider16.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results
// held after a one-cycle done pulse until the next accepted start.
module seq_divider16
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] r, q, d;
  logic [CNT_W-1:0] count;
  logic             pend, accept, done_r, dbz_r;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic [WIDTH:0]   trial_a, t;
  logic             borrow, unused_t_msb;
  logic [WIDTH-1:0] r_nx, q_nx;

  assign trial_a = {r, q[WIDTH-1]};

  cla17_sub_step u_sub (
    .a      (trial_a),
    .b      ({1'b0, d}),
    .diff   (t),
    .borrow (borrow)
  );

  // R < D holds every step, so a non-borrowing difference always fits in WIDTH bits.
  assign unused_t_msb = t[WIDTH];
  assign r_nx = borrow ? trial_a[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_nx = {q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (pend) begin
          state_nx = DONE;
        end else if (start) begin
          accept = 1'b1;
          if (divisor != '0) state_nx = CALC;
        end
      end
      CALC:    if (count == LAST) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Divide-by-zero waits one cycle in pend so done lands one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r      <= '0;
      q      <= '0;
      d      <= '0;
      count  <= '0;
      pend   <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        d     <= divisor;
        q     <= dividend;
        r     <= '0;
        count <= '0;
        dbz_r <= 1'b0;
        pend  <= (divisor == '0);
      end else if (pend) begin
        pend   <= 1'b0;
        done_r <= 1'b1;
        dbz_r  <= 1'b1;
        quot_r <= DIV0_QUOTIENT;
        rem_r  <= q;
      end else if (state == CALC) begin
        r     <= r_nx;
        q     <= q_nx;
        count <= count + 1'b1;
        if (count == LAST) begin
          done_r <= 1'b1;
          quot_r <= q_nx;
          rem_r  <= r_nx;
        end
      end
    end
  end

  assign busy        = (state == CALC);
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign quotient    = quot_r;
  assign remainder   = rem_r;
endmodule
